ifu_prefetch_buffer: RTL

Parametrised instruction-fetch front end for the RISC-V core. It replaces the single-cycle combinational fetch with an autonomous fetcher: it issues sequential word requests to instruction memory and tolerates variable response latency. Returned instructions are buffered in a DEPTH-entry FIFO and handed to decode over a valid/ready handshake. Decode or execute can redirect the fetch PC, which flushes the FIFO and discards in-flight responses.

---
 rtl/ifu_prefetch_buffer.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/ifu_prefetch_buffer.sv
// ifu_prefetch_buffer: autonomous sequential fetcher feeding decode from a DEPTH-entry {pc, instr} FIFO; redirect flushes the FIFO and drops stale responses.
// Latency: a response taken at edge N is presented on out_* in cycle N+1; a redirect at edge N issues the new request in cycle N+1.
// Backpressure: requests need a free slot counting buffered plus in-flight words, so a stalled decode stops fetch without overflowing the FIFO.
// Optional feature macro IFU_EBREAK_HALT_EN: flag an ebreak word at the head and stop fetching once one has been buffered.
module ifu_prefetch_buffer #(
   parameter int unsigned      WIDTH    = 32,
   parameter int unsigned      DEPTH    = 4,
   parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(32'h8000_0000)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             redirect_valid,
   input  logic [WIDTH-1:0] redirect_pc,
   output logic             mem_req_valid,
   input  logic             mem_req_ready,
   output logic [WIDTH-1:0] mem_req_addr,
   input  logic             mem_rsp_valid,
   input  logic [WIDTH-1:0] mem_rsp_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_instr,
   output logic [WIDTH-1:0] out_pc,
   output logic             out_ebreak
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] fetch_pc;
   logic [WIDTH-1:0] rsp_pc;
   logic [WIDTH-1:0] fifo_pc    [DEPTH];
   logic [WIDTH-1:0] fifo_instr [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic [CW-1:0]    inflight;
   logic [CW-1:0]    discard;
   logic             halted;
   logic             req_hold;
   logic [CW:0]      occupancy;
   logic             credit_ok;
   logic             req_fire;
   logic             push;
   logic             pop;
   logic [WIDTH-1:0] redirect_base;

   // low two bits of a redirect target are ignored: fetch is always word aligned
   assign redirect_base = redirect_pc & ~WIDTH'(3);

   // a slot is reserved at request time, so buffered plus outstanding words never exceed DEPTH
   assign occupancy = {1'b0, count} + {1'b0, inflight};
   assign credit_ok = occupancy < (CW + 1)'(DEPTH);

   // req_hold keeps an unaccepted request (and its address) stable even if halt sets meanwhile;
   // gating with rst_n keeps the request low while reset is asserted
   assign mem_req_valid = rst_n && !redirect_valid && (req_hold || (!halted && credit_ok));
   assign mem_req_addr  = fetch_pc;
   assign req_fire      = mem_req_valid && mem_req_ready;

   // responses are dropped while stale ones remain, and also during the redirect cycle itself
   assign push = mem_rsp_valid && !redirect_valid && (discard == '0);

   assign out_valid = (count != '0) && !redirect_valid;
   assign pop       = out_valid && out_ready;
   assign out_instr = fifo_instr[rd_ptr];
   assign out_pc    = fifo_pc[rd_ptr];

   // FIFO storage: each kept response is written together with the PC it was fetched from
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            fifo_pc[i]    <= '0;
            fifo_instr[i] <= '0;
         end
      end else if (push) begin
         fifo_pc[wr_ptr]    <= rsp_pc;
         fifo_instr[wr_ptr] <= mem_rsp_data;
      end
   end

   // fetch/response PCs, FIFO pointers and the outstanding/stale response counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc <= RESET_PC;
         rsp_pc   <= RESET_PC;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         inflight <= '0;
         discard  <= '0;
         req_hold <= 1'b0;
      end else if (redirect_valid) begin
         fetch_pc <= redirect_base;
         rsp_pc   <= redirect_base;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         inflight <= inflight - CW'(mem_rsp_valid);
         // every outstanding response belongs to an abandoned path (inflight already covers
         // the ones marked by an earlier redirect), so all of them except the one dropped now remain to be discarded
         discard  <= inflight - CW'(mem_rsp_valid);
         req_hold <= 1'b0;
      end else begin
         if (req_fire) begin
            fetch_pc <= fetch_pc + WIDTH'(4);
         end
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
            rsp_pc <= rsp_pc + WIDTH'(4);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         count    <= count + CW'(push) - CW'(pop);
         inflight <= inflight + CW'(req_fire) - CW'(mem_rsp_valid);
         if (mem_rsp_valid && (discard != '0)) begin
            discard <= discard - CW'(1);
         end
         req_hold <= mem_req_valid && !mem_req_ready;
      end
   end

`ifdef IFU_EBREAK_HALT_EN
   localparam logic [WIDTH-1:0] EBREAK = WIDTH'(32'h0010_0073);

   // stop issuing once an ebreak word is buffered; outstanding responses still land, a redirect restarts fetch
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         halted <= 1'b0;
      end else if (redirect_valid) begin
         halted <= 1'b0;
      end else if (push && (mem_rsp_data == EBREAK)) begin
         halted <= 1'b1;
      end
   end

   assign out_ebreak = out_valid && (out_instr == EBREAK);
`else
   assign halted     = 1'b0;
   assign out_ebreak = 1'b0;
`endif

endmodule
